// File: rtl/ycr_cclk_pkg.sv
// Shared types for the N-channel core clock-gate controller.
package ycr_cclk_pkg;

  typedef enum logic [2:0] {
    CCLK_ON       = 3'd0,
    CCLK_OFF      = 3'd1,
    CCLK_AUTO     = 3'd2,
    CCLK_AUTO_IRQ = 3'd3
  } cclk_mode_e;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_IDLE_WAIT,
    ST_GATED,
    ST_WAKE
  } cclk_st_e;

  // Reserved encodings 4-7 fall through to ON, so only the two AUTO codes gate.
  function automatic logic cclk_is_auto(input logic [2:0] mode);
    return (mode == CCLK_AUTO) || (mode == CCLK_AUTO_IRQ);
  endfunction

endpackage

// File: rtl/ctech_clk_gate.sv
// Latch-based integrated clock gate: enable is captured while CLK is low so GCLK never glitches.
module ctech_clk_gate (
  input  logic GATE,
  input  logic CLK,
  output logic GCLK
);

  logic r_en;

  always_latch begin
    if (!CLK) r_en <= GATE;
  end

  assign GCLK = CLK & r_en;

endmodule

// File: rtl/ycr_cclk_gate_ch.sv
// One gated clock channel: mode-driven FSM, idle hysteresis and wake timeout counters, ICG.
//   state        | meaning
//   ST_RUN       | clock running, watching for idle
//   ST_IDLE_WAIT | idle seen, counting hysteresis before gating
//   ST_GATED     | clock stopped, waiting for a wake source
//   ST_WAKE      | clock running, wakeup asserted until dst leaves idle or timeout
module ycr_cclk_gate_ch
  import ycr_cclk_pkg::*;
#(
  parameter int IRQ_W      = 3,
  parameter int IDLE_CNT_W = 8,
  parameter int WAKE_TMO   = 16
) (
  input  logic                  clk_in,
  input  logic                  reset_n,
  input  logic [2:0]            cfg_mode,
  input  logic [IDLE_CNT_W-1:0] cfg_idle_dly,
  input  logic [IRQ_W-1:0]      cfg_irq_mask,
  input  logic                  dst_idle,
  input  logic                  src_req,
  input  logic [IRQ_W-1:0]      irq,
  output logic                  clk_enb,
  output logic                  wakeup,
  output logic                  clk_out
);

  localparam int WCNT_W = $clog2(WAKE_TMO + 1);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WAKE_TMO - 1);

  cclk_st_e              r_state;
  logic [IDLE_CNT_W-1:0] r_idle_cnt;
  logic [WCNT_W-1:0]     r_wake_cnt;
  logic                  r_clk_enb;
  logic                  r_wakeup;

  logic w_auto;
  logic w_off;
  logic w_wk;
  logic w_idl;

  assign w_auto = cclk_is_auto(cfg_mode);
  assign w_off  = (cfg_mode == CCLK_OFF);
  assign w_wk   = src_req | ((cfg_mode == CCLK_AUTO_IRQ) & |(irq & cfg_irq_mask));
  assign w_idl  = dst_idle & ~src_req;

  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      r_state    <= ST_RUN;
      r_idle_cnt <= '0;
      r_wake_cnt <= '0;
      r_clk_enb  <= 1'b1;
      r_wakeup   <= 1'b0;
    end else if (!w_auto) begin
      r_idle_cnt <= '0;
      r_wake_cnt <= '0;
      r_wakeup   <= 1'b0;
      r_state    <= w_off ? ST_GATED : ST_RUN;
      r_clk_enb  <= ~w_off;
    end else begin
      case (r_state)
        ST_RUN: begin
          r_clk_enb <= 1'b1;
          r_wakeup  <= 1'b0;
          if (w_idl && !w_wk) begin
            if (cfg_idle_dly == '0) begin
              r_state   <= ST_GATED;
              r_clk_enb <= 1'b0;
            end else begin
              r_state    <= ST_IDLE_WAIT;
              r_idle_cnt <= cfg_idle_dly - IDLE_CNT_W'(1);
            end
          end
        end
        ST_IDLE_WAIT: begin
          // Any wake, including one landing on the gating edge, aborts the countdown.
          if (!w_idl || w_wk) begin
            r_state    <= ST_RUN;
            r_idle_cnt <= '0;
          end else if (r_idle_cnt == '0) begin
            r_state   <= ST_GATED;
            r_clk_enb <= 1'b0;
          end else begin
            r_idle_cnt <= r_idle_cnt - IDLE_CNT_W'(1);
          end
        end
        ST_GATED: begin
          r_clk_enb <= 1'b0;
          if (w_wk) begin
            r_state    <= ST_WAKE;
            r_clk_enb  <= 1'b1;
            r_wakeup   <= 1'b1;
            r_wake_cnt <= '0;
          end
        end
        ST_WAKE: begin
          r_clk_enb <= 1'b1;
          if (!dst_idle || r_wake_cnt == WCNT_LAST) begin
            r_state    <= ST_RUN;
            r_wakeup   <= 1'b0;
            r_wake_cnt <= '0;
          end else begin
            r_wake_cnt <= r_wake_cnt + WCNT_W'(1);
          end
        end
        default: begin
          r_state   <= ST_RUN;
          r_clk_enb <= 1'b1;
          r_wakeup  <= 1'b0;
        end
      endcase
    end
  end

  assign clk_enb = r_clk_enb;
  assign wakeup  = r_wakeup;

  ctech_clk_gate u_icg (
    .GATE (r_clk_enb),
    .CLK  (clk_in),
    .GCLK (clk_out)
  );

endmodule

// File: rtl/ycr_cclk_gate_ctrl_n.sv
// N-channel core clock-gate controller: slices shared config buses into independent channels.
module ycr_cclk_gate_ctrl_n
  import ycr_cclk_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int IRQ_W      = 3,
  parameter int IDLE_CNT_W = 8,
  parameter int WAKE_TMO   = 16
) (
  input  logic                    clk_in,
  input  logic                    reset_n,
  input  logic [NUM_CH*3-1:0]     cfg_mode,
  input  logic [IDLE_CNT_W-1:0]   cfg_idle_dly,
  input  logic [NUM_CH*IRQ_W-1:0] cfg_irq_mask,
  input  logic [NUM_CH-1:0]       dst_idle,
  input  logic [NUM_CH-1:0]       src_req,
  input  logic [IRQ_W-1:0]        irq,
  output logic [NUM_CH-1:0]       clk_enb,
  output logic [NUM_CH-1:0]       wakeup,
  output logic [NUM_CH-1:0]       clk_out
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    ycr_cclk_gate_ch #(
      .IRQ_W      (IRQ_W),
      .IDLE_CNT_W (IDLE_CNT_W),
      .WAKE_TMO   (WAKE_TMO)
    ) u_ch (
      .clk_in       (clk_in),
      .reset_n      (reset_n),
      .cfg_mode     (cfg_mode[3*g +: 3]),
      .cfg_idle_dly (cfg_idle_dly),
      .cfg_irq_mask (cfg_irq_mask[IRQ_W*g +: IRQ_W]),
      .dst_idle     (dst_idle[g]),
      .src_req      (src_req[g]),
      .irq          (irq),
      .clk_enb      (clk_enb[g]),
      .wakeup       (wakeup[g]),
      .clk_out      (clk_out[g])
    );
  end

endmodule

// File: tb/tb_ycr_cclk_gate_ctrl_n.sv
// Scoreboard bench for ycr_cclk_gate_ctrl_n: stimulus queues timed expectations, a monitor checks them.
module tb_ycr_cclk_gate_ctrl_n;

  logic        clk_in = 1'b0;
  logic        reset_n;
  logic [11:0] cfg_mode;
  logic [7:0]  cfg_idle_dly;
  logic [11:0] cfg_irq_mask;
  logic [3:0]  dst_idle;
  logic [3:0]  src_req;
  logic [2:0]  irq;
  logic [3:0]  clk_enb;
  logic [3:0]  wakeup;
  logic [3:0]  clk_out;

  ycr_cclk_gate_ctrl_n dut (
    .clk_in       (clk_in),
    .reset_n      (reset_n),
    .cfg_mode     (cfg_mode),
    .cfg_idle_dly (cfg_idle_dly),
    .cfg_irq_mask (cfg_irq_mask),
    .dst_idle     (dst_idle),
    .src_req      (src_req),
    .irq          (irq),
    .clk_enb      (clk_enb),
    .wakeup       (wakeup),
    .clk_out      (clk_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int         due;
    logic [3:0] m;
    logic [3:0] enb;
    logic [3:0] wk;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   glitches = 0;
  int   pulses [4];
  logic [3:0] prev_out = 4'b0;

  always @(posedge clk_in) cyc <= cyc + 1;

  // Every gated-clock edge must coincide with the same-direction edge of clk_in.
  initial for (int i = 0; i < 4; i++) pulses[i] = 0;
  always @(clk_out) begin
    for (int i = 0; i < 4; i++) begin
      if (prev_out[i] === 1'b0 && clk_out[i] === 1'b1) begin
        pulses[i] = pulses[i] + 1;
        if (clk_in !== 1'b1) glitches = glitches + 1;
      end
      if (prev_out[i] === 1'b1 && clk_out[i] === 1'b0 && clk_in !== 1'b0)
        glitches = glitches + 1;
    end
    prev_out = clk_out;
  end

  always @(negedge clk_in) begin
    for (int j = sb.size() - 1; j >= 0; j--) begin
      if (sb[j].due == cyc) begin
        checks = checks + 1;
        if (((clk_enb & sb[j].m) !== (sb[j].enb & sb[j].m)) ||
            ((wakeup & sb[j].m) !== (sb[j].wk & sb[j].m))) begin
          errors = errors + 1;
          $display("FAIL %s cyc=%0d ch=%h clk_enb got %h want %h wakeup got %h want %h",
                   sb[j].name, cyc, sb[j].m, clk_enb & sb[j].m, sb[j].enb & sb[j].m,
                   wakeup & sb[j].m, sb[j].wk & sb[j].m);
        end
        sb.delete(j);
      end else if (sb[j].due < cyc) begin
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL %s stale expectation due=%0d now=%0d", sb[j].name, sb[j].due, cyc);
        sb.delete(j);
      end
    end
  end

  task automatic push_exp(input int k, input logic [3:0] m, input logic [3:0] e,
                          input logic [3:0] w, input string nm);
    exp_t x;
    x.due  = cyc + k;
    x.m    = m;
    x.enb  = e;
    x.wk   = w;
    x.name = nm;
    sb.push_back(x);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic chk(input string nm, input int act, input int req);
    checks = checks + 1;
    if (act != req) begin
      errors = errors + 1;
      $display("FAIL %s got %0d want %0d", nm, act, req);
    end
  endtask

  task automatic set_mode(input int ch, input logic [2:0] m);
    cfg_mode[3*ch +: 3] = m;
  endtask

  int snap [4];

  initial begin
    #100000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n      = 1'b0;
    cfg_mode     = '0;
    cfg_idle_dly = '0;
    cfg_irq_mask = '0;
    dst_idle     = '0;
    src_req      = '0;
    irq          = '0;

    // Reset held three edges, all channels ON
    tick(2);
    push_exp(1, 4'hF, 4'hF, 4'h0, "reset");
    tick(1);
    reset_n = 1'b1;

    // ON ignores idle; gated clocks keep toggling
    dst_idle = 4'hF;
    push_exp(1, 4'hF, 4'hF, 4'h0, "on_idle");
    tick(1);
    dst_idle = 4'hA;
    push_exp(2, 4'hF, 4'hF, 4'h0, "on_idle2");
    for (int i = 0; i < 4; i++) snap[i] = pulses[i];
    tick(4);
    for (int i = 0; i < 4; i++) chk("on_clk_out_pulses", pulses[i] - snap[i], 4);
    dst_idle = 4'h0;

    // AUTO hysteresis D=5: clk_enb falls 6 edges after idle sampled
    set_mode(0, 3'd2);
    cfg_idle_dly = 8'd5;
    tick(1);
    dst_idle[0] = 1'b1;
    for (int k = 1; k <= 5; k++) push_exp(k, 4'h1, 4'h1, 4'h0, "hyst_hold");
    push_exp(6, 4'h1, 4'h0, 4'h0, "hyst_gate");
    tick(6);
    src_req[0] = 1'b1;
    push_exp(1, 4'h1, 4'h1, 4'h1, "hyst_wake");
    tick(1);
    src_req[0]  = 1'b0;
    dst_idle[0] = 1'b0;
    push_exp(1, 4'h1, 4'h1, 4'h0, "hyst_wake_exit");
    tick(1);
    // Idle drops after 3 edges: never gates
    dst_idle[0] = 1'b1;
    for (int k = 1; k <= 3; k++) push_exp(k, 4'h1, 4'h1, 4'h0, "abort_hold");
    tick(3);
    dst_idle[0] = 1'b0;
    for (int k = 1; k <= 4; k++) push_exp(k, 4'h1, 4'h1, 4'h0, "abort_run");
    tick(4);

    // Zero delay gating, 1-cycle src_req wake, wake timeout of 16
    cfg_idle_dly = 8'd0;
    dst_idle[0]  = 1'b1;
    push_exp(1, 4'h1, 4'h0, 4'h0, "zero_dly_gate");
    tick(1);
    src_req[0] = 1'b1;
    push_exp(1, 4'h1, 4'h1, 4'h1, "req_wake");
    tick(1);
    src_req[0] = 1'b0;
    for (int k = 1; k <= 15; k++) push_exp(k, 4'h1, 4'h1, 4'h1, "wake_hold");
    push_exp(16, 4'h1, 4'h1, 4'h0, "wake_tmo");
    push_exp(17, 4'h1, 4'h0, 4'h0, "wake_regate");
    tick(17);

    // IRQ wake with mask: ch1 AUTO_IRQ mask 010, ch2 AUTO (mask ignored)
    cfg_irq_mask[5:3] = 3'b010;
    cfg_irq_mask[8:6] = 3'b010;
    set_mode(1, 3'd3);
    set_mode(2, 3'd2);
    dst_idle[2:1] = 2'b11;
    push_exp(1, 4'h6, 4'h0, 4'h0, "irq_gate");
    tick(1);
    irq = 3'b001;
    push_exp(1, 4'h6, 4'h0, 4'h0, "irq_masked");
    push_exp(2, 4'h6, 4'h0, 4'h0, "irq_masked2");
    tick(2);
    irq = 3'b010;
    push_exp(1, 4'h6, 4'h2, 4'h2, "irq_wake_ch1");
    tick(1);
    irq = 3'b000;
    dst_idle[1] = 1'b0;
    push_exp(1, 4'h6, 4'h2, 4'h0, "irq_dst_busy");
    tick(1);

    // Wake on the gating edge of IDLE_WAIT returns to RUN
    cfg_idle_dly = 8'd2;
    dst_idle[1]  = 1'b1;
    push_exp(1, 4'h2, 4'h2, 4'h0, "iw_hold1");
    push_exp(2, 4'h2, 4'h2, 4'h0, "iw_hold2");
    tick(2);
    irq = 3'b010;
    push_exp(1, 4'h2, 4'h2, 4'h0, "iw_wake_wins");
    tick(1);
    irq = 3'b000;
    dst_idle[1]  = 1'b0;
    cfg_idle_dly = 8'd0;
    push_exp(1, 4'h2, 4'h2, 4'h0, "iw_back_run");
    tick(1);

    // Forced modes on ch3
    set_mode(3, 3'd2);
    dst_idle[3] = 1'b1;
    push_exp(1, 4'h8, 4'h0, 4'h0, "ch3_auto_gate");
    tick(1);
    set_mode(3, 3'd1);
    push_exp(1, 4'h8, 4'h0, 4'h0, "ch3_off");
    tick(1);
    snap[3] = pulses[3];
    src_req[3] = 1'b1;
    push_exp(1, 4'h8, 4'h0, 4'h0, "ch3_off_req");
    tick(1);
    src_req[3] = 1'b0;
    tick(1);
    chk("off_clk_out_pulses", pulses[3] - snap[3], 0);
    set_mode(3, 3'd0);
    push_exp(1, 4'h8, 4'h8, 4'h0, "ch3_force_on");
    tick(1);
    set_mode(3, 3'd2);
    push_exp(1, 4'h8, 4'h0, 4'h0, "ch3_regate");
    tick(1);
    set_mode(3, 3'd7);
    push_exp(1, 4'h8, 4'h8, 4'h0, "ch3_reserved_on");
    tick(1);

    // Reset in WAKE with wake counter at 9
    src_req[0] = 1'b1;
    push_exp(1, 4'h1, 4'h1, 4'h1, "mid_wake");
    tick(1);
    src_req[0] = 1'b0;
    for (int k = 1; k <= 9; k++) push_exp(k, 4'h1, 4'h1, 4'h1, "mid_wake_hold");
    tick(9);
    reset_n = 1'b0;
    push_exp(1, 4'hF, 4'hF, 4'h0, "mid_reset");
    tick(1);
    reset_n = 1'b1;
    push_exp(1, 4'h1, 4'h0, 4'h0, "post_reset_gate");
    tick(3);

    chk("scoreboard_drained", sb.size(), 0);
    chk("clk_out_glitches", glitches, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
